// File: rtl/reset_sequencer.sv
// Multi-domain reset generator: synchronises the board reset, stretches it, then
// releases the domain resets in staggered order with per-channel soft re-reset.
module reset_sequencer #(
  parameter int N_OUT       = 4,
  parameter int WIDTH       = 1000,
  parameter int STAGGER     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             ip_async_reset_i,
  input  logic             ip_reset_i,
  input  logic [N_OUT-1:0] ip_chan_reset_i,
  output logic [N_OUT-1:0] op_reset_o,
  output logic             op_done_o
);

  // state   | meaning
  // HOLD    | all outputs asserted, counting WIDTH clean edges
  // RELEASE | dropping one output every STAGGER edges, index 0 first
  // DONE    | sequence complete, channels may be re-reset individually
  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  localparam int HCW  = $clog2(WIDTH + 1);
  localparam int SCW  = (STAGGER == 0) ? 1 : $clog2(STAGGER + 1);
  localparam int IDXW = (N_OUT == 1) ? 1 : $clog2(N_OUT);

  localparam logic [HCW-1:0]  HOLD_TC  = HCW'(WIDTH - 1);
  localparam logic [SCW-1:0]  STG_TC   = SCW'((STAGGER == 0) ? 0 : STAGGER - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_OUT - 1);
  // No stagger to walk through: everything drops on the hold exit edge.
  localparam bit FAST_RELEASE = (STAGGER == 0) || (N_OUT == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_s;
  logic                   src;

  logic [1:0]       state_q, state_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [SCW-1:0]   stg_cnt_q, stg_cnt_d;
  logic [IDXW-1:0]  rel_idx_q, rel_idx_d;
  logic [N_OUT-1:0] rst_q, rst_d;
  logic             done_q, done_d;
  logic [HCW-1:0]   chan_cnt_q [N_OUT];
  logic [HCW-1:0]   chan_cnt_d [N_OUT];

  always_ff @(posedge clk or posedge ip_async_reset_i) begin
    if (ip_async_reset_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_s = sync_q[SYNC_STAGES-1];
  assign src   = rst_s | ip_reset_i;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stg_cnt_d  = stg_cnt_q;
    rel_idx_d  = rel_idx_q;
    rst_d      = rst_q;
    done_d     = done_q;
    for (int k = 0; k < N_OUT; k++) begin
      chan_cnt_d[k] = chan_cnt_q[k];
    end

    if (src) begin
      state_d    = ST_HOLD;
      hold_cnt_d = '0;
      stg_cnt_d  = '0;
      rel_idx_d  = '0;
      rst_d      = '1;
      done_d     = 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        chan_cnt_d[k] = '0;
      end
    end else begin
      case (state_q)
        ST_HOLD: begin
          rst_d  = '1;
          done_d = 1'b0;
          if (hold_cnt_q == HOLD_TC) begin
            stg_cnt_d = '0;
            if (FAST_RELEASE) begin
              rst_d   = '0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              rst_d[0]  = 1'b0;
              rel_idx_d = IDXW'(1);
              state_d   = ST_RELEASE;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          done_d = 1'b0;
          if (stg_cnt_q == STG_TC) begin
            stg_cnt_d = '0;
            for (int k = 0; k < N_OUT; k++) begin
              if (IDXW'(k) == rel_idx_q) rst_d[k] = 1'b0;
            end
            if (rel_idx_q == LAST_IDX) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              rel_idx_d = rel_idx_q + 1'b1;
            end
          end else begin
            stg_cnt_d = stg_cnt_q + 1'b1;
          end
        end

        ST_DONE: begin
          // Each channel re-uses the hold length, counted from its last request edge.
          for (int k = 0; k < N_OUT; k++) begin
            if (ip_chan_reset_i[k]) begin
              rst_d[k]      = 1'b1;
              chan_cnt_d[k] = '0;
            end else if (rst_q[k]) begin
              if (chan_cnt_q[k] == HOLD_TC) begin
                rst_d[k] = 1'b0;
              end else begin
                chan_cnt_d[k] = chan_cnt_q[k] + 1'b1;
              end
            end
          end
          done_d = ~|rst_d;
        end

        default: begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          rst_d      = '1;
          done_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge ip_async_reset_i) begin
    if (ip_async_reset_i) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      stg_cnt_q  <= '0;
      rel_idx_q  <= '0;
      rst_q      <= '1;
      done_q     <= 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        chan_cnt_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
      rel_idx_q  <= rel_idx_d;
      rst_q      <= rst_d;
      done_q     <= done_d;
      for (int k = 0; k < N_OUT; k++) begin
        chan_cnt_q[k] <= chan_cnt_d[k];
      end
    end
  end

  assign op_reset_o = rst_q;
  assign op_done_o  = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: main config plus STAGGER=0 and N_OUT=1/WIDTH=1 instances.
module tb_reset_sequencer;

  logic       clk;
  logic       rst_a;
  logic       rst_g;
  logic [3:0] chan_m;
  logic [3:0] chan_z;
  logic [0:0] chan_n;

  logic [3:0] rst_m;
  logic       done_m;
  logic [3:0] rst_z;
  logic       done_z;
  logic [0:0] rst_n;
  logic       done_n;

  int checks;
  int failures;

  reset_sequencer #(.N_OUT(4), .WIDTH(8), .STAGGER(4), .SYNC_STAGES(2)) u_main (
    .clk(clk), .ip_async_reset_i(rst_a), .ip_reset_i(rst_g),
    .ip_chan_reset_i(chan_m), .op_reset_o(rst_m), .op_done_o(done_m)
  );

  reset_sequencer #(.N_OUT(4), .WIDTH(8), .STAGGER(0), .SYNC_STAGES(2)) u_zero (
    .clk(clk), .ip_async_reset_i(rst_a), .ip_reset_i(rst_g),
    .ip_chan_reset_i(chan_z), .op_reset_o(rst_z), .op_done_o(done_z)
  );

  reset_sequencer #(.N_OUT(1), .WIDTH(1), .STAGGER(16), .SYNC_STAGES(2)) u_one (
    .clk(clk), .ip_async_reset_i(rst_a), .ip_reset_i(rst_g),
    .ip_chan_reset_i(chan_n), .op_reset_o(rst_n), .op_done_o(done_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (rst_m !== 4'b1111 || done_m !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_main: got rst=%b done=%b exp rst=1111 done=0", rst_m, done_m);
    end
    checks++;
    if (rst_z !== 4'b1111 || done_z !== 1'b0 || rst_n !== 1'b1 || done_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_degen: got z=%b/%b n=%b/%b exp 1111/0 1/0", rst_z, done_z, rst_n, done_n);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rst_m !== 4'b1111 || done_m !== 1'b0) begin
        failures++;
        $display("FAIL reset_held: got rst=%b done=%b exp rst=1111 done=0", rst_m, done_m);
      end
    end
  endtask

  // Called right after an edge: that edge is edge 0, release happens before edge 1.
  task automatic test_power_on();
    logic [3:0] exp;
    rst_a = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      step();
      for (int k = 0; k < 4; k++) exp[k] = (e < 10 + 4 * k);
      checks++;
      if (rst_m !== exp || done_m !== (e >= 22)) begin
        failures++;
        $display("FAIL power_on e=%0d: got rst=%b done=%b exp rst=%b done=%b", e, rst_m, done_m, exp, (e >= 22));
      end
      checks++;
      if (rst_z !== (e >= 10 ? 4'b0000 : 4'b1111) || done_z !== (e >= 10)) begin
        failures++;
        $display("FAIL power_on_stagger0 e=%0d: got rst=%b done=%b", e, rst_z, done_z);
      end
      checks++;
      if (rst_n !== (e < 3) || done_n !== (e >= 3)) begin
        failures++;
        $display("FAIL power_on_n1 e=%0d: got rst=%b done=%b exp rst=%b", e, rst_n, done_n, (e < 3));
      end
    end
  endtask

  task automatic test_stretch();
    logic [3:0] exp;
    rst_g = 1'b1;
    step();
    rst_g = 1'b0;
    checks++;
    if (rst_m !== 4'b1111 || done_m !== 1'b0) begin
      failures++;
      $display("FAIL stretch_assert: got rst=%b done=%b exp rst=1111 done=0", rst_m, done_m);
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      for (int k = 0; k < 4; k++) exp[k] = (i < 8 + 4 * k);
      checks++;
      if (rst_m !== exp || done_m !== (i >= 20)) begin
        failures++;
        $display("FAIL stretch i=%0d: got rst=%b done=%b exp rst=%b done=%b", i, rst_m, done_m, exp, (i >= 20));
      end
    end
  endtask

  task automatic test_retrigger();
    logic [3:0] exp;
    rst_g = 1'b1;
    step();
    rst_g = 1'b0;
    for (int i = 1; i <= 12; i++) step();
    checks++;
    if (rst_m !== 4'b1100) begin
      failures++;
      $display("FAIL retrigger_pre: got rst=%b exp rst=1100", rst_m);
    end
    rst_g = 1'b1;
    step();
    rst_g = 1'b0;
    checks++;
    if (rst_m !== 4'b1111 || done_m !== 1'b0) begin
      failures++;
      $display("FAIL retrigger_assert: got rst=%b done=%b exp rst=1111 done=0", rst_m, done_m);
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      for (int k = 0; k < 4; k++) exp[k] = (i < 8 + 4 * k);
      checks++;
      if (rst_m !== exp || done_m !== (i >= 20)) begin
        failures++;
        $display("FAIL retrigger i=%0d: got rst=%b done=%b exp rst=%b", i, rst_m, done_m, exp);
      end
    end
  endtask

  task automatic test_chan_reset();
    logic [3:0] exp;
    step();
    chan_m = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rst_m !== 4'b0100 || done_m !== 1'b0) begin
        failures++;
        $display("FAIL chan_req i=%0d: got rst=%b done=%b exp rst=0100 done=0", i, rst_m, done_m);
      end
    end
    chan_m = 4'b0000;
    for (int i = 3; i <= 11; i++) begin
      step();
      checks++;
      if (rst_m !== (i < 10 ? 4'b0100 : 4'b0000) || done_m !== (i >= 10)) begin
        failures++;
        $display("FAIL chan_hold i=%0d: got rst=%b done=%b exp done=%b", i, rst_m, done_m, (i >= 10));
      end
    end
    // Channel request during RELEASE must not disturb the stagger.
    rst_g = 1'b1;
    step();
    rst_g = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      chan_m = (i >= 9 && i <= 14) ? 4'b0100 : 4'b0000;
      step();
      for (int k = 0; k < 4; k++) exp[k] = (i < 8 + 4 * k);
      checks++;
      if (rst_m !== exp || done_m !== (i >= 20)) begin
        failures++;
        $display("FAIL chan_in_release i=%0d: got rst=%b done=%b exp rst=%b", i, rst_m, done_m, exp);
      end
    end
    chan_m = 4'b0000;
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp;
    step();
    chan_m = 4'b0010;
    rst_g  = 1'b1;
    step();
    chan_m = 4'b0000;
    rst_g  = 1'b0;
    checks++;
    if (rst_m !== 4'b1111 || done_m !== 1'b0) begin
      failures++;
      $display("FAIL simul_global_wins: got rst=%b done=%b exp rst=1111 done=0", rst_m, done_m);
    end
    for (int i = 1; i <= 20; i++) begin
      step();
      for (int k = 0; k < 4; k++) exp[k] = (i < 8 + 4 * k);
      checks++;
      if (rst_m !== exp || done_m !== (i >= 20)) begin
        failures++;
        $display("FAIL simul_seq i=%0d: got rst=%b done=%b exp rst=%b", i, rst_m, done_m, exp);
      end
    end
    // Async assertion from DONE takes effect between edges.
    #2;
    rst_a = 1'b1;
    #1;
    checks++;
    if (rst_m !== 4'b1111 || done_m !== 1'b0) begin
      failures++;
      $display("FAIL async_immediate: got rst=%b done=%b exp rst=1111 done=0", rst_m, done_m);
    end
    step();
    rst_a = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_a = 1'b1;
    step();
    checks++;
    if (rst_m !== 4'b1111 || done_m !== 1'b0) begin
      failures++;
      $display("FAIL async_mid_hold: got rst=%b done=%b exp rst=1111 done=0", rst_m, done_m);
    end
    step();
    rst_a = 1'b0;
    for (int e = 1; e <= 22; e++) begin
      step();
      for (int k = 0; k < 4; k++) exp[k] = (e < 10 + 4 * k);
      checks++;
      if (rst_m !== exp || done_m !== (e >= 22)) begin
        failures++;
        $display("FAIL async_restart e=%0d: got rst=%b done=%b exp rst=%b", e, rst_m, done_m, exp);
      end
    end
  endtask

  task automatic test_degenerate();
    rst_g = 1'b1;
    step();
    rst_g = 1'b0;
    checks++;
    if (rst_n !== 1'b1 || done_n !== 1'b0 || rst_z !== 4'b1111) begin
      failures++;
      $display("FAIL degen_assert: got n=%b/%b z=%b exp n=1/0 z=1111", rst_n, done_n, rst_z);
    end
    for (int i = 1; i <= 9; i++) begin
      step();
      checks++;
      if (rst_n !== 1'b0 || done_n !== 1'b1) begin
        failures++;
        $display("FAIL degen_n1 i=%0d: got rst=%b done=%b exp rst=0 done=1", i, rst_n, done_n);
      end
      checks++;
      if (rst_z !== (i < 8 ? 4'b1111 : 4'b0000) || done_z !== (i >= 8)) begin
        failures++;
        $display("FAIL degen_stagger0 i=%0d: got rst=%b done=%b exp done=%b", i, rst_z, done_z, (i >= 8));
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_a    = 1'b1;
    rst_g    = 1'b0;
    chan_m   = 4'b0000;
    chan_z   = 4'b0000;
    chan_n   = 1'b0;
    test_reset();
    test_power_on();
    test_stretch();
    test_retrigger();
    test_chan_reset();
    test_simultaneous();
    test_degenerate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
